// File: rtl/multicycle_control_fsm.sv
// Control sequencer for a multicycle RISC-V style datapath: walks one instruction through
// fetch/decode/execute/memory/write-back states, stalling on the memory valid/ready handshake.
module multicycle_control_fsm #(
   parameter int OP_CODE_WIDTH = 7,
   parameter int FUNCT3_WIDTH  = 3,
   parameter int FUNCT7_WIDTH  = 7,
   parameter int STATE_WIDTH   = 4
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic [OP_CODE_WIDTH-1:0] i_op_code,
   input  logic [FUNCT3_WIDTH-1:0]  i_funct3,
   input  logic [FUNCT7_WIDTH-1:0]  i_funct7,
   input  logic                     i_alu_zero_flag,
   input  logic                     i_mem_ready,
   output logic                     o_mem_req,
   output logic                     o_mem_we,
   output logic                     o_addr_sel,
   output logic                     o_ir_wr_en,
   output logic                     o_pc_wr_en,
   output logic                     o_pc_src,
   output logic [1:0]               o_alu_src_a,
   output logic [1:0]               o_alu_src_b,
   output logic [FUNCT3_WIDTH-1:0]  o_alu_op,
   output logic                     o_alu_sub,
   output logic [1:0]               o_imm_sel,
   output logic                     o_reg_file_wr_en,
   output logic [1:0]               o_wb_result_sel,
   output logic                     o_illegal_instr,
   output logic [STATE_WIDTH-1:0]   o_state
);

   localparam logic [OP_CODE_WIDTH-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OP_CODE_WIDTH-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OP_CODE_WIDTH-1:0] OP_R_TYPE = 7'b0110011;
   localparam logic [OP_CODE_WIDTH-1:0] OP_INT_IMM = 7'b0010011;
   localparam logic [OP_CODE_WIDTH-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OP_CODE_WIDTH-1:0] OP_JAL    = 7'b1101111;
   localparam logic [OP_CODE_WIDTH-1:0] OP_JALR   = 7'b1100111;

   typedef enum logic [STATE_WIDTH-1:0] {
      ST_IDLE      = 4'd0,
      ST_FETCH     = 4'd1,
      ST_DECODE    = 4'd2,
      ST_MEM_ADDR  = 4'd3,
      ST_MEM_READ  = 4'd4,
      ST_MEM_WB    = 4'd5,
      ST_MEM_WRITE = 4'd6,
      ST_EXEC_R    = 4'd7,
      ST_EXEC_I    = 4'd8,
      ST_ALU_WB    = 4'd9,
      ST_BRANCH    = 4'd10,
      ST_JAL       = 4'd11,
      ST_JALR_EXEC = 4'd12,
      ST_JALR_WB   = 4'd13,
      ST_TRAP      = 4'd14
   } state_t;

   // Controls that depend only on the state; kept in flops alongside the state register.
   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       addr_sel;
      logic       pc_src;
      logic       pc_wr;
      logic [1:0] src_a;
      logic [1:0] src_b;
      logic       rf_we;
      logic [1:0] wb_sel;
      logic       illegal;
   } ctrl_t;

   localparam ctrl_t CTRL_NONE = {$bits(ctrl_t){1'b0}};

   state_t state_r;
   state_t next_state_s;
   ctrl_t  ctrl_r;
   logic [1:0]              imm_sel_s;
   logic [FUNCT3_WIDTH-1:0] alu_op_s;
   logic                    alu_sub_s;
   logic                    branch_taken_s;
   logic                    fetch_done_s;
   logic                    unused_funct7_s;

   function automatic ctrl_t ctrl_for(input state_t s);
      ctrl_t c;
      c = CTRL_NONE;
      case (s)
         ST_FETCH: begin
            c.mem_req = 1'b1;
            c.src_b   = 2'b10;
         end
         ST_DECODE: begin
            c.src_a = 2'b01;
            c.src_b = 2'b01;
         end
         ST_MEM_ADDR, ST_EXEC_I, ST_JALR_EXEC: begin
            c.src_a = 2'b10;
            c.src_b = 2'b01;
         end
         ST_MEM_READ: begin
            c.mem_req  = 1'b1;
            c.addr_sel = 1'b1;
         end
         ST_MEM_WB: begin
            c.rf_we  = 1'b1;
            c.wb_sel = 2'b00;
         end
         ST_MEM_WRITE: begin
            c.mem_req  = 1'b1;
            c.mem_we   = 1'b1;
            c.addr_sel = 1'b1;
         end
         ST_EXEC_R: begin
            c.src_a = 2'b10;
            c.src_b = 2'b00;
         end
         ST_ALU_WB: begin
            c.rf_we  = 1'b1;
            c.wb_sel = 2'b01;
         end
         ST_BRANCH: begin
            c.src_a  = 2'b10;
            c.src_b  = 2'b00;
            c.pc_src = 1'b1;
         end
         // rd receives the already-incremented PC on the same edge the PC takes the target
         ST_JAL, ST_JALR_WB: begin
            c.pc_src = 1'b1;
            c.pc_wr  = 1'b1;
            c.rf_we  = 1'b1;
            c.wb_sel = 2'b10;
         end
         ST_TRAP: begin
            c.illegal = 1'b1;
         end
         default: begin
            c = CTRL_NONE;
         end
      endcase
      return c;
   endfunction

   // Next-state selection from the current state, the instruction fields and the memory handshake.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE:  next_state_s = ST_FETCH;
         ST_FETCH: next_state_s = i_mem_ready ? ST_DECODE : ST_FETCH;
         ST_DECODE: begin
            case (i_op_code)
               OP_LOAD, OP_STORE: next_state_s = ST_MEM_ADDR;
               OP_R_TYPE:         next_state_s = ST_EXEC_R;
               OP_INT_IMM:        next_state_s = ST_EXEC_I;
               OP_BRANCH:         next_state_s = ST_BRANCH;
               OP_JAL:            next_state_s = ST_JAL;
               OP_JALR:           next_state_s = ST_JALR_EXEC;
               default:           next_state_s = ST_TRAP;
            endcase
         end
         ST_MEM_ADDR: begin
            if (i_funct3 != 3'b010) begin
               next_state_s = ST_TRAP;
            end else if (i_op_code == OP_STORE) begin
               next_state_s = ST_MEM_WRITE;
            end else begin
               next_state_s = ST_MEM_READ;
            end
         end
         ST_MEM_READ:  next_state_s = i_mem_ready ? ST_MEM_WB : ST_MEM_READ;
         ST_MEM_WB:    next_state_s = ST_FETCH;
         ST_MEM_WRITE: next_state_s = i_mem_ready ? ST_FETCH : ST_MEM_WRITE;
         ST_EXEC_R:    next_state_s = ST_ALU_WB;
         ST_EXEC_I:    next_state_s = ST_ALU_WB;
         ST_ALU_WB:    next_state_s = ST_FETCH;
         ST_BRANCH: begin
            if ((i_funct3 == 3'b000) || (i_funct3 == 3'b001)) begin
               next_state_s = ST_FETCH;
            end else begin
               next_state_s = ST_TRAP;
            end
         end
         ST_JAL:       next_state_s = ST_FETCH;
         ST_JALR_EXEC: next_state_s = ST_JALR_WB;
         ST_JALR_WB:   next_state_s = ST_FETCH;
         ST_TRAP:      next_state_s = ST_TRAP;
         default:      next_state_s = ST_TRAP;
      endcase
   end

   // Field-qualified controls: these follow the instruction register and the zero flag directly,
   // since the IR is only loaded on the fetch-completing edge.
   always_comb begin
      imm_sel_s      = 2'b00;
      alu_op_s       = 3'b000;
      alu_sub_s      = 1'b0;
      branch_taken_s = 1'b0;
      case (state_r)
         ST_DECODE: begin
            case (i_op_code)
               OP_JAL:    imm_sel_s = 2'b11;
               OP_STORE:  imm_sel_s = 2'b01;
               OP_BRANCH: imm_sel_s = 2'b10;
               default:   imm_sel_s = 2'b00;
            endcase
         end
         ST_MEM_ADDR: begin
            imm_sel_s = (i_op_code == OP_STORE) ? 2'b01 : 2'b00;
         end
         ST_EXEC_R: begin
            alu_op_s  = i_funct3;
            alu_sub_s = ((i_funct3 == 3'b000) || (i_funct3 == 3'b101)) && i_funct7[5];
         end
         ST_EXEC_I: begin
            alu_op_s  = i_funct3;
            alu_sub_s = (i_funct3 == 3'b101) && i_funct7[5];
         end
         ST_BRANCH: begin
            alu_sub_s      = 1'b1;
            branch_taken_s = ((i_funct3 == 3'b000) &&  i_alu_zero_flag) ||
                             ((i_funct3 == 3'b001) && !i_alu_zero_flag);
         end
         default: begin
            alu_sub_s = 1'b0;
         end
      endcase
   end

   // State register plus the state-only controls for the state being entered.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_r <= ST_IDLE;
         ctrl_r  <= CTRL_NONE;
      end else begin
         state_r <= next_state_s;
         ctrl_r  <= ctrl_for(next_state_s);
      end
   end

   assign fetch_done_s    = (state_r == ST_FETCH) && i_mem_ready;
   assign unused_funct7_s = ^{i_funct7[FUNCT7_WIDTH-1:6], i_funct7[4:0]};

   assign o_mem_req        = ctrl_r.mem_req;
   assign o_mem_we         = ctrl_r.mem_we;
   assign o_addr_sel       = ctrl_r.addr_sel;
   assign o_ir_wr_en       = fetch_done_s;
   assign o_pc_wr_en       = ctrl_r.pc_wr | fetch_done_s | branch_taken_s;
   assign o_pc_src         = ctrl_r.pc_src;
   assign o_alu_src_a      = ctrl_r.src_a;
   assign o_alu_src_b      = ctrl_r.src_b;
   assign o_alu_op         = alu_op_s;
   assign o_alu_sub        = alu_sub_s;
   assign o_imm_sel        = imm_sel_s;
   assign o_reg_file_wr_en = ctrl_r.rf_we;
   assign o_wb_result_sel  = ctrl_r.wb_sel;
   assign o_illegal_instr  = ctrl_r.illegal;
   assign o_state          = state_r;

endmodule
